// File: rtl/norm_pkg.sv
// ---------------------------------------------------------------------------
// norm_pkg
// Shared definitions for the mantissa normalisation pipeline.
//
// Contents:
//   DEF_SIZE_DATA  default mantissa width
//   DEF_SIZE_LOPD  default width of the leading-one position
//   DEF_SIZE_EXP   default biased exponent width
//   norm_res_t     one normalised result at the default widths
//                  {mant, exp, zero, underflow}, packed so it can be
//                  compared as a single word
// ---------------------------------------------------------------------------
package norm_pkg;

  localparam int DEF_SIZE_DATA = 24;
  localparam int DEF_SIZE_LOPD = 5;
  localparam int DEF_SIZE_EXP  = 8;

  typedef struct packed {
    logic [DEF_SIZE_DATA-1:0] mant;
    logic [DEF_SIZE_EXP-1:0]  exp;
    logic                     zero;
    logic                     underflow;
  } norm_res_t;

endpackage

// File: rtl/norm_barrel_shl.sv
// ---------------------------------------------------------------------------
// norm_barrel_shl
// Purely combinational logarithmic left shifter. Stage k shifts by 2**k when
// bit k of the shift amount is set, so SIZE_LOPD stages cover any amount
// that the leading-one position can express. Bits shifted past the MSB are
// lost and zeros come in at the LSB.
//
// Ports:
//   data_i   [SIZE_DATA-1:0]  word to shift
//   shamt_i  [SIZE_LOPD-1:0]  left shift amount
//   data_o   [SIZE_DATA-1:0]  data_i << shamt_i
// ---------------------------------------------------------------------------
module norm_barrel_shl
  import norm_pkg::*;
#(
  parameter int SIZE_DATA = DEF_SIZE_DATA,
  parameter int SIZE_LOPD = DEF_SIZE_LOPD
) (
  input  logic [SIZE_DATA-1:0] data_i,
  input  logic [SIZE_LOPD-1:0] shamt_i,
  output logic [SIZE_DATA-1:0] data_o
);

  // stageData[k] is the partial result after the first k shift stages.
  logic [SIZE_DATA-1:0] stageData [SIZE_LOPD+1];

  assign stageData[0] = data_i;

  // One mux level per shift-amount bit, weights 1, 2, 4, ...
  for (genvar k = 0; k < SIZE_LOPD; k++) begin : gStage
    assign stageData[k+1] = shamt_i[k] ? (stageData[k] << (2**k)) : stageData[k];
  end

  assign data_o = stageData[SIZE_LOPD];

endmodule

// File: rtl/norm_shift_pipe.sv
// ---------------------------------------------------------------------------
// norm_shift_pipe
// Two-stage floating-point mantissa normaliser with valid/ready handshakes.
// Stage S1 registers the shift amount and the clamp decision (normal,
// denormal, or zero); stage S2 registers the barrel-shifted mantissa. With no
// backpressure the result appears exactly two cycles after the operand and
// one result per cycle is sustained.
//
// Optional feature (macro NORM_UFLOW_CNT_EN):
//   adds o_uflow_cnt, a saturating 16-bit count of delivered results that
//   had o_underflow set, cleared by i_rst.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst           synchronous active-high reset
//   i_valid/o_ready upstream handshake (transfer when both high)
//   i_mant          unnormalised mantissa
//   i_exp           biased exponent before normalisation
//   i_one_position  leading-one index of i_mant (0 = LSB)
//   i_zero_flag     i_mant is zero
//   o_valid/i_ready downstream handshake (transfer when both high)
//   o_mant          normalised mantissa
//   o_exp           adjusted exponent
//   o_zero          result is exact zero
//   o_underflow     result is denormal, exponent clamped to 0
//   o_uflow_cnt     underflow result count (NORM_UFLOW_CNT_EN only)
// ---------------------------------------------------------------------------
module norm_shift_pipe
  import norm_pkg::*;
#(
  parameter int SIZE_DATA = DEF_SIZE_DATA,
  parameter int SIZE_LOPD = DEF_SIZE_LOPD,
  parameter int SIZE_EXP  = DEF_SIZE_EXP
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_mant,
  input  logic [SIZE_EXP-1:0]  i_exp,
  input  logic [SIZE_LOPD-1:0] i_one_position,
  input  logic                 i_zero_flag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_mant,
  output logic [SIZE_EXP-1:0]  o_exp,
  output logic                 o_zero,
  output logic                 o_underflow
`ifdef NORM_UFLOW_CNT_EN
  ,
  output logic [15:0]          o_uflow_cnt
`endif
);

  // Comparison width wide enough for both the exponent and the shift amount,
  // plus a spare bit so neither side can wrap.
  localparam int CW = ((SIZE_EXP > SIZE_LOPD + 1) ? SIZE_EXP : SIZE_LOPD + 1) + 1;

  localparam logic [SIZE_LOPD:0] DATA_W  = (SIZE_LOPD+1)'(SIZE_DATA);
  localparam logic [SIZE_LOPD:0] TOP_IDX = (SIZE_LOPD+1)'(SIZE_DATA - 1);

  // Handshake
  logic s1Advance;
  logic s2Advance;

  // S1 state
  logic                 s1Valid_q;
  logic [SIZE_DATA-1:0] s1Mant_q,  s1Mant_d;
  logic [SIZE_LOPD-1:0] s1Shift_q, s1Shift_d;
  logic [SIZE_EXP-1:0]  s1Exp_q,   s1Exp_d;
  logic                 s1Zero_q,  s1Zero_d;
  logic                 s1Uflow_q, s1Uflow_d;

  // S2 state (drives the outputs)
  logic                 s2Valid_q;
  logic [SIZE_DATA-1:0] s2Mant_q, s2Mant_d;
  logic [SIZE_EXP-1:0]  s2Exp_q;
  logic                 s2Zero_q;
  logic                 s2Uflow_q;

  // Decision helpers
  logic [SIZE_LOPD:0] posExt;
  logic [SIZE_LOPD:0] shAmt;

  // Each stage moves forward when it is empty or when the stage after it is
  // moving; S2's successor is the downstream consumer. This lets a full
  // pipe accept a new operand in the same cycle the oldest result leaves.
  assign s2Advance = !s2Valid_q || i_ready;
  assign s1Advance = !s1Valid_q || s2Advance;
  assign o_ready   = s1Advance;

  // S1 next state: pick the shift amount and how the exponent is clamped.
  // A leading-one index beyond the mantissa is treated as the top bit
  // (no shift). A normal result needs exponent > shift; otherwise the shift
  // is limited to exponent-1 so the exponent lands on the denormal value 0,
  // and a zero exponent means the mantissa is already denormal as given.
  always_comb begin
    posExt    = {1'b0, i_one_position};
    s1Mant_d  = i_mant;
    s1Shift_d = '0;
    s1Exp_d   = '0;
    s1Zero_d  = 1'b0;
    s1Uflow_d = 1'b0;

    if (posExt >= DATA_W) begin
      posExt = TOP_IDX;
    end
    shAmt = TOP_IDX - posExt;

    if (i_zero_flag) begin
      s1Mant_d = '0;
      s1Zero_d = 1'b1;
    end else if (CW'(i_exp) > CW'(shAmt)) begin
      s1Shift_d = shAmt[SIZE_LOPD-1:0];
      s1Exp_d   = i_exp - SIZE_EXP'(shAmt);
    end else if (i_exp != '0) begin
      s1Shift_d = SIZE_LOPD'(i_exp - SIZE_EXP'(1));
      s1Uflow_d = 1'b1;
    end else begin
      s1Uflow_d = 1'b1;
    end
  end

  // S1 register: capture a new operand whenever the stage advances. The
  // payload only loads on a real transfer so bubbles do not toggle it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1Valid_q <= 1'b0;
      s1Mant_q  <= '0;
      s1Shift_q <= '0;
      s1Exp_q   <= '0;
      s1Zero_q  <= 1'b0;
      s1Uflow_q <= 1'b0;
    end else if (s1Advance) begin
      s1Valid_q <= i_valid;
      if (i_valid) begin
        s1Mant_q  <= s1Mant_d;
        s1Shift_q <= s1Shift_d;
        s1Exp_q   <= s1Exp_d;
        s1Zero_q  <= s1Zero_d;
        s1Uflow_q <= s1Uflow_d;
      end
    end
  end

  // The actual mantissa shift happens between S1 and S2.
  norm_barrel_shl #(
    .SIZE_DATA (SIZE_DATA),
    .SIZE_LOPD (SIZE_LOPD)
  ) uShifter (
    .data_i  (s1Mant_q),
    .shamt_i (s1Shift_q),
    .data_o  (s2Mant_d)
  );

  // S2 register: holds the result stable while the consumer stalls, and
  // only reloads when it advances with a valid item coming from S1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2Valid_q <= 1'b0;
      s2Mant_q  <= '0;
      s2Exp_q   <= '0;
      s2Zero_q  <= 1'b0;
      s2Uflow_q <= 1'b0;
    end else if (s2Advance) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Mant_q  <= s2Mant_d;
        s2Exp_q   <= s1Exp_q;
        s2Zero_q  <= s1Zero_q;
        s2Uflow_q <= s1Uflow_q;
      end
    end
  end

  assign o_valid     = s2Valid_q;
  assign o_mant      = s2Mant_q;
  assign o_exp       = s2Exp_q;
  assign o_zero      = s2Zero_q;
  assign o_underflow = s2Uflow_q;

`ifdef NORM_UFLOW_CNT_EN
  logic [15:0] uflowCnt_q;

  // Count delivered denormal results; the counter sticks at all-ones
  // instead of wrapping so a long run never reports a small number.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      uflowCnt_q <= '0;
    end else if (s2Valid_q && i_ready && s2Uflow_q && (uflowCnt_q != 16'hFFFF)) begin
      uflowCnt_q <= uflowCnt_q + 16'd1;
    end
  end

  assign o_uflow_cnt = uflowCnt_q;
`endif

endmodule

// File: tb/tb_norm_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_norm_shift_pipe
// Self-checking bench for norm_shift_pipe at default widths. A scoreboard
// queue holds the expected result of every accepted operand together with
// the cycle it entered the pipe; the pipe is modelled as a two-deep
// in-order buffer in which an item becomes visible one edge after entry.
// Honours NORM_UFLOW_CNT_EN for the optional counter port.
// ---------------------------------------------------------------------------
module tb_norm_shift_pipe;
  import norm_pkg::*;

  typedef struct {
    norm_res_t res;
    int        enter;
  } item_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [23:0] i_mant = '0;
  logic [7:0]  i_exp = '0;
  logic [4:0]  i_one_position = '0;
  logic        i_zero_flag = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [23:0] o_mant;
  logic [7:0]  o_exp;
  logic        o_zero;
  logic        o_underflow;
`ifdef NORM_UFLOW_CNT_EN
  logic [15:0] o_uflow_cnt;
  int          uflowModel = 0;
`endif

  int        checks = 0;
  int        passes = 0;
  int        cyc = 0;
  int        holdStart = -100;
  int        readyMode = 0;
  int        readyLowSeen = 0;
  item_t     sb[$];
  norm_res_t pendExp = '0;
  bit        pendHave = 1'b0;

  norm_shift_pipe dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_mant         (i_mant),
    .i_exp          (i_exp),
    .i_one_position (i_one_position),
    .i_zero_flag    (i_zero_flag),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_mant         (o_mant),
    .o_exp          (o_exp),
    .o_zero         (o_zero),
    .o_underflow    (o_underflow)
`ifdef NORM_UFLOW_CNT_EN
    ,
    .o_uflow_cnt    (o_uflow_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end else begin
      passes++;
    end
  endtask

  // Normalisation rules written directly as arithmetic on the operand.
  function automatic norm_res_t refModel(input longint m, input longint e, input longint p, input bit z);
    norm_res_t r;
    longint    sh;
    r = '0;
    if (z) begin
      r.zero = 1'b1;
      return r;
    end
    if (p >= DEF_SIZE_DATA) p = DEF_SIZE_DATA - 1;
    sh = DEF_SIZE_DATA - 1 - p;
    if (e > sh) begin
      r.mant = 24'(m << sh);
      r.exp  = 8'(e - sh);
    end else if (e != 0) begin
      r.mant      = 24'(m << (e - 1));
      r.underflow = 1'b1;
    end else begin
      r.mant      = 24'(m);
      r.underflow = 1'b1;
    end
    return r;
  endfunction

  // Reference leading-one detector feeding the random operands.
  function automatic void leadingOne(input logic [23:0] m, output logic [4:0] p, output bit z);
    z = (m == '0);
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) p = 5'(i);
    end
  endfunction

  // Downstream ready: always on, randomly throttled, or forced low for a
  // three-cycle window starting at holdStart.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (cyc >= holdStart && cyc < holdStart + 3) i_ready = 1'b0;
      else if (readyMode == 0) i_ready = 1'b1;
      else i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard, evaluated on the falling edge where everything is stable.
  always @(negedge i_clk) begin
    if (i_rst) begin
      sb.delete();
`ifdef NORM_UFLOW_CNT_EN
      uflowModel = 0;
`endif
    end else begin
      bit vExp;
      vExp = (sb.size() > 0) && (sb[0].enter < cyc);
      if (!o_ready) readyLowSeen++;
      checkOutput("o_ready", 64'(o_ready), 64'((sb.size() < 2) || i_ready));
      checkOutput("o_valid", 64'(o_valid), 64'(vExp));
      if (vExp) begin
        checkOutput("payload", 64'({o_mant, o_exp, o_zero, o_underflow}), 64'(sb[0].res));
      end
`ifdef NORM_UFLOW_CNT_EN
      checkOutput("uflow_cnt", 64'(o_uflow_cnt), 64'(uflowModel));
`endif
      if (vExp && i_ready) begin
`ifdef NORM_UFLOW_CNT_EN
        if (sb[0].res.underflow && uflowModel < 65535) uflowModel++;
`endif
        void'(sb.pop_front());
      end
      if (i_valid && o_ready) begin
        item_t it;
        it.res   = pendHave ? pendExp : refModel(i_mant, i_exp, i_one_position, i_zero_flag);
        it.enter = cyc + 1;
        sb.push_back(it);
      end
    end
  end

  // Present one operand and hold it until the pipe accepts it.
  task automatic applyStimulus(input logic [23:0] m, input logic [7:0] e, input logic [4:0] p,
                               input logic z, input norm_res_t er, input bit have);
    bit acc;
    int guard;
    guard = 0;
    i_valid = 1'b1;
    i_mant = m;
    i_exp = e;
    i_one_position = p;
    i_zero_flag = z;
    pendExp = er;
    pendHave = have;
    do begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
    i_valid = 1'b0;
    pendHave = 1'b0;
  endtask

  task automatic applyRandom();
    logic [23:0] m;
    logic [4:0]  p;
    bit          z;
    int          w;
    logic [7:0]  e;
    w = $urandom_range(0, 24);
    m = 24'($urandom) & 24'((64'd1 << w) - 1);
    e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
    leadingOne(m, p, z);
    applyStimulus(m, e, p, z, '0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic applyReset(input int n);
    i_rst = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rst_valid", 64'(o_valid), 64'd0);
    checkOutput("rst_ready", 64'(o_ready), 64'd1);
    checkOutput("rst_mant", 64'(o_mant), 64'd0);
    checkOutput("rst_exp", 64'(o_exp), 64'd0);
    checkOutput("rst_zero", 64'(o_zero), 64'd0);
    checkOutput("rst_uflow", 64'(o_underflow), 64'd0);
`ifdef NORM_UFLOW_CNT_EN
    checkOutput("rst_cnt", 64'(o_uflow_cnt), 64'd0);
`endif
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    applyReset(2);
    readyMode = 0;

    $display("[TB] directed vectors");
    applyStimulus(24'h000001, 8'd100, 5'd0,  1'b0, '{24'h800000, 8'd77, 1'b0, 1'b0}, 1'b1);
    applyStimulus(24'h000000, 8'd50,  5'd17, 1'b1, '{24'h000000, 8'd0,  1'b1, 1'b0}, 1'b1);
    applyStimulus(24'h000100, 8'd10,  5'd8,  1'b0, '{24'h020000, 8'd0,  1'b0, 1'b1}, 1'b1);
    applyStimulus(24'h000100, 8'd15,  5'd8,  1'b0, '{24'h400000, 8'd0,  1'b0, 1'b1}, 1'b1);
    applyStimulus(24'h000100, 8'd16,  5'd8,  1'b0, '{24'h800000, 8'd1,  1'b0, 1'b0}, 1'b1);
    applyStimulus(24'h000ABC, 8'd0,   5'd11, 1'b0, '{24'h000ABC, 8'd0,  1'b0, 1'b1}, 1'b1);
    applyStimulus(24'h123456, 8'd5,   5'd30, 1'b0, '{24'h123456, 8'd5,  1'b0, 1'b0}, 1'b1);
    applyStimulus(24'hC00000, 8'd1,   5'd23, 1'b0, '{24'hC00000, 8'd1,  1'b0, 1'b0}, 1'b1);
    drain();

    $display("[TB] stream with downstream stall");
    readyLowSeen = 0;
    holdStart = cyc + 3;
    for (int i = 0; i < 8; i++) applyRandom();
    drain();
    checkOutput("ready_dropped", 64'(readyLowSeen > 0), 64'd1);

    $display("[TB] reset with items in flight");
    applyStimulus(24'h0F0000, 8'd120, 5'd19, 1'b0, '0, 1'b0);
    applyStimulus(24'h000003, 8'd2,   5'd1,  1'b0, '0, 1'b0);
    applyReset(1);
    repeat (6) @(posedge i_clk);
    #1;

    $display("[TB] random operands");
    readyMode = 1;
    for (int i = 0; i < 100; i++) applyRandom();
    readyMode = 0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
